// File: rtl/serial_compare.sv
// serial_compare: MSB-first sequential magnitude comparator.
// Latches x/y on an accepted start, then examines one bit pair per clock.
// It stops at the first differing bit, or after bit 0 when all bits match.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           request a comparison (only honoured while idle)
//   x, y            unsigned operands, latched on the accepted start edge
//   busy            comparison in progress
//   done            one-cycle pulse; flags are valid from this cycle onward
//   gt, lt, eq      result flags (exactly one set after the first result)
//   o               same as gt, bit-compatible with the combinational comparator
//   cycles          bit positions examined for the last result (1..WIDTH)
module serial_compare #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             lt,
  output logic             eq,
  output logic             o,
  output logic [CNT_W-1:0] cycles
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   x_reg, x_next;
  logic [WIDTH-1:0]   y_reg, y_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;
  logic               gt_reg, gt_next;
  logic               lt_reg, lt_next;
  logic               eq_reg, eq_next;
  logic [CNT_W-1:0]   cycles_reg, cycles_next;

  logic               bit_x;
  logic               bit_y;

  assign bit_x = x_reg[idx_reg];
  assign bit_y = y_reg[idx_reg];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      x_reg      <= '0;
      y_reg      <= '0;
      idx_reg    <= '0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      gt_reg     <= 1'b0;
      lt_reg     <= 1'b0;
      eq_reg     <= 1'b0;
      cycles_reg <= '0;
    end else begin
      state_reg  <= state_next;
      x_reg      <= x_next;
      y_reg      <= y_next;
      idx_reg    <= idx_next;
      cnt_reg    <= cnt_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
      gt_reg     <= gt_next;
      lt_reg     <= lt_next;
      eq_reg     <= eq_next;
      cycles_reg <= cycles_next;
    end
  end

  always_comb begin
    // Hold everything by default; done is a pulse so it defaults low.
    state_next  = state_reg;
    x_next      = x_reg;
    y_next      = y_reg;
    idx_next    = idx_reg;
    cnt_next    = cnt_reg;
    busy_next   = busy_reg;
    done_next   = 1'b0;
    gt_next     = gt_reg;
    lt_next     = lt_reg;
    eq_next     = eq_reg;
    cycles_next = cycles_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          x_next     = x;
          y_next     = y;
          idx_next   = IDX_W'(WIDTH - 1);
          cnt_next   = '0;
          busy_next  = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        cnt_next = cnt_reg + CNT_W'(1);
        if (bit_x != bit_y) begin
          // First differing bit from the top decides the magnitude.
          gt_next     = bit_x;
          lt_next     = ~bit_x;
          eq_next     = 1'b0;
          cycles_next = cnt_reg + CNT_W'(1);
          done_next   = 1'b1;
          busy_next   = 1'b0;
          state_next  = IDLE;
        end else if (idx_reg == '0) begin
          gt_next     = 1'b0;
          lt_next     = 1'b0;
          eq_next     = 1'b1;
          cycles_next = CNT_W'(WIDTH);
          done_next   = 1'b1;
          busy_next   = 1'b0;
          state_next  = IDLE;
        end else begin
          idx_next = idx_reg - IDX_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy   = busy_reg;
  assign done   = done_reg;
  assign gt     = gt_reg;
  assign lt     = lt_reg;
  assign eq     = eq_reg;
  assign o      = gt_reg;
  assign cycles = cycles_reg;

endmodule

// File: tb/tb_serial_compare.sv
// tb_serial_compare: directed vector table plus hand-written handshake,
// back-to-back and mid-operation reset sequences for serial_compare.
module tb_serial_compare;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] x, y;
  logic       busy, done, gt, lt, eq, o;
  logic [2:0] cycles;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_compare #(.WIDTH(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x(x), .y(y),
    .busy(busy), .done(done), .gt(gt), .lt(lt), .eq(eq), .o(o),
    .cycles(cycles)
  );

  typedef struct {
    logic [3:0] vx;
    logic [3:0] vy;
    logic       egt;
    logic       elt;
    logic       eeq;
    int         ecyc;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called #1 after a posedge. Issues one start, scrambles operands after the
  // accept edge, and waits (bounded) for done. lat = edges from E0 to done.
  task automatic run_cmp(input logic [3:0] a, input logic [3:0] b, output int lat);
    start = 1'b1;
    x = a;
    y = b;
    tick();
    start = 1'b0;
    x = 4'($urandom);
    y = 4'($urandom);
    check("busy_after_accept", int'(busy), 1);
    check("done_low_after_accept", int'(done), 0);
    lat = 0;
    while (!done && lat < 8) begin
      if (busy && done) check("busy_done_overlap", 1, 0);
      tick();
      lat++;
    end
    check("done_seen", int'(done), 1);
  endtask

  task automatic check_result(input string tag, input logic egt, input logic elt,
                              input logic eeq, input int ecyc);
    check({tag, "_gt"}, int'(gt), int'(egt));
    check({tag, "_lt"}, int'(lt), int'(elt));
    check({tag, "_eq"}, int'(eq), int'(eeq));
    check({tag, "_o"}, int'(o), int'(egt));
    check({tag, "_cycles"}, int'(cycles), ecyc);
    check({tag, "_busy"}, int'(busy), 0);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_gt"}, int'(gt), 0);
    check({tag, "_lt"}, int'(lt), 0);
    check({tag, "_eq"}, int'(eq), 0);
    check({tag, "_o"}, int'(o), 0);
    check({tag, "_cycles"}, int'(cycles), 0);
  endtask

  initial begin
    int lat;

    vecs[0] = '{4'd9,  4'd3,  1'b1, 1'b0, 1'b0, 1};
    vecs[1] = '{4'd5,  4'd4,  1'b1, 1'b0, 1'b0, 4};
    vecs[2] = '{4'd2,  4'd3,  1'b0, 1'b1, 1'b0, 4};
    vecs[3] = '{4'd6,  4'd6,  1'b0, 1'b0, 1'b1, 4};
    vecs[4] = '{4'd0,  4'd15, 1'b0, 1'b1, 1'b0, 1};
    vecs[5] = '{4'd15, 4'd15, 1'b0, 1'b0, 1'b1, 4};
    vecs[6] = '{4'd8,  4'd12, 1'b0, 1'b1, 1'b0, 2};
    vecs[7] = '{4'd10, 4'd11, 1'b0, 1'b1, 1'b0, 4};
    vecs[8] = '{4'd7,  4'd5,  1'b1, 1'b0, 1'b0, 3};
    vecs[9] = '{4'd4,  4'd2,  1'b1, 1'b0, 1'b0, 2};

    // Reset held with start asserted.
    rst_n = 1'b0;
    start = 1'b1;
    x = 4'd9;
    y = 4'd3;
    repeat (3) tick();
    check_cleared("reset");
    rst_n = 1'b1;
    start = 1'b0;
    repeat (2) tick();
    check_cleared("post_reset_idle");

    // Table-driven vectors.
    foreach (vecs[i]) begin
      run_cmp(vecs[i].vx, vecs[i].vy, lat);
      check_result($sformatf("vec%0d", i), vecs[i].egt, vecs[i].elt,
                   vecs[i].eeq, vecs[i].ecyc);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].ecyc);
      $display("vec%0d x=%0d y=%0d gt=%0b lt=%0b eq=%0b cycles=%0d lat=%0d",
               i, vecs[i].vx, vecs[i].vy, gt, lt, eq, cycles, lat);
      tick();
      check($sformatf("vec%0d_done_pulse", i), int'(done), 0);
    end

    // Flags hold while idle (last vector: 4 vs 2, gt, cycles=2).
    for (int k = 0; k < 10; k++) begin
      tick();
      if (gt !== 1'b1 || lt !== 1'b0 || eq !== 1'b0 || cycles !== 3'd2 || done !== 1'b0)
        check($sformatf("hold_cycle%0d", k), 0, 1);
      else
        check($sformatf("hold_cycle%0d", k), 1, 1);
    end
    $display("hold gt=%0b cycles=%0d over 10 idle cycles", gt, cycles);

    // Start while busy is ignored: 1 vs 1, with a 15 vs 0 pulse at RUN edge 2.
    start = 1'b1;
    x = 4'd1;
    y = 4'd1;
    tick();                         // E0
    start = 1'b0;
    tick();                         // RUN edge 1
    start = 1'b1;
    x = 4'd15;
    y = 4'd0;
    tick();                         // RUN edge 2
    start = 1'b0;
    lat = 2;
    while (!done && lat < 8) begin
      tick();
      lat++;
    end
    check("busy_ignore_done", int'(done), 1);
    check_result("busy_ignore", 1'b0, 1'b0, 1'b1, 4);
    check("busy_ignore_latency", lat, 4);
    $display("busy_ignore gt=%0b lt=%0b eq=%0b cycles=%0d lat=%0d", gt, lt, eq, cycles, lat);

    // Back-to-back: start during the done cycle.
    run_cmp(4'd0, 4'd8, lat);
    check_result("b2b", 1'b0, 1'b1, 1'b0, 1);
    check("b2b_latency", lat, 1);
    $display("b2b x=0 y=8 gt=%0b lt=%0b eq=%0b cycles=%0d lat=%0d", gt, lt, eq, cycles, lat);

    // Mid-operation reset: 3 vs 2 needs 4 edges; reset after 2.
    tick();
    start = 1'b1;
    x = 4'd3;
    y = 4'd2;
    tick();                         // E0
    start = 1'b0;
    repeat (2) tick();
    check("midrst_busy_before", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check_cleared("midrst");
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("midrst_no_done%0d", k), int'(done), 0);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("midrst_release_idle%0d", k), int'(busy | done), 0);
    end
    $display("midrst cleared busy=%0b done=%0b", busy, done);
    run_cmp(4'd7, 4'd7, lat);
    check_result("after_rst", 1'b0, 1'b0, 1'b1, 4);
    check("after_rst_latency", lat, 4);
    $display("after_rst x=7 y=7 gt=%0b lt=%0b eq=%0b cycles=%0d lat=%0d", gt, lt, eq, cycles, lat);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
